// File: rtl/axis_store_forward_buffer.sv
// axis_store_forward_buffer: store-and-forward AXI-Stream packet buffer.
// Beats are held until their packet's tlast is written; only whole packets
// are exposed on the egress side. Packets that cannot fit are dropped whole.
// Build option: define AXIS_SF_DROP_COUNT_EN to build the drop counter;
// otherwise drop_count is tied to zero and the counter is not built.
module axis_store_forward_buffer #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int DEPTH       = 64,
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [31:0]            drop_count
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_W      = ADDR_WIDTH + 1;
  localparam int ENTRY_W    = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;

  typedef enum logic {
    ACCEPT,
    DROP
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   wr_ptr, wr_next;
  logic [PTR_W-1:0]   commit_ptr, commit_next;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   used;
  logic               full;
  logic               store;
  logic               read;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign used          = wr_ptr - rd_ptr;
  assign full          = (used == PTR_W'(DEPTH));
  assign m_axis_tvalid = (rd_ptr != commit_ptr);
  assign read          = m_axis_tvalid & m_axis_tready;

  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} =
    mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Beat storage: accepted beats land at the write pointer.
  always_ff @(posedge axis_aclk) begin
    if (store) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end
  end

  // State and pointer registers; reset discards everything buffered.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_next;
      commit_ptr <= commit_next;
      if (read) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Next-state, pointer updates and ingress ready.
  // A full buffer holding only an uncommitted packet can never drain, so the
  // partial packet is rewound away and the remainder is swallowed in DROP.
  always_comb begin
    state_next    = state;
    wr_next       = wr_ptr;
    commit_next   = commit_ptr;
    s_axis_tready = 1'b0;
    store         = 1'b0;
    unique case (state)
      ACCEPT: begin
        s_axis_tready = axis_resetn & ~full;
        if (s_axis_tvalid && s_axis_tready) begin
          store   = 1'b1;
          wr_next = wr_ptr + PTR_W'(1);
          if (s_axis_tlast) begin
            commit_next = wr_ptr + PTR_W'(1);
          end
        end else if (full && (commit_ptr == rd_ptr) && s_axis_tvalid) begin
          wr_next    = commit_ptr;
          state_next = DROP;
        end
      end
      DROP: begin
        s_axis_tready = axis_resetn;
        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

`ifdef AXIS_SF_DROP_COUNT_EN
  logic [31:0] drop_cnt;
  logic        drop_done;

  assign drop_done  = (state == DROP) & s_axis_tvalid & s_axis_tready & s_axis_tlast;
  assign drop_count = drop_cnt;

  // Saturating count of packets dropped for oversize.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      drop_cnt <= '0;
    end else if (drop_done && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule
